sw_debounce: RTL and testbench

- Board-input conditioning stage between the slide-switch pins and the combinational switch-to-LED logic.
- Synchronizes each raw switch bit to the system clock, then filters contact bounce.
- Presents a clean, debounced vector that downstream combinational logic consumes directly in place of raw switch inputs.
- Optionally emits single-cycle rise/fall pulses per bit for future counter and FSM exercises.

---
 rtl/sw_debounce_if.sv | 10 +
 rtl/sw_debounce.sv | 60 ++++++
 tb/tb_sw_debounce.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sw_debounce_if.sv
// sw_debounce_if: raw switch input and conditioned outputs of sw_debounce.
interface sw_debounce_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             settled;
  modport master (output sw, input sw_db, rise, fall, settled);
  modport slave (input sw, output sw_db, rise, fall, settled);
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit 2-flop sync plus stability-count debounce; rise/fall pulses under SW_DEBOUNCE_EDGE_EN.
module sw_debounce #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  bus
);
  logic [WIDTH-1:0]            s1, s2, db_q, db_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        settled_q, settled_d;
  always_comb begin
    db_d = db_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_W'(CNT_MAX - 1)) db_d[i] = s2[i];
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    // s1 becomes s2 on this edge, so it is the synced input seen after the edge
    settled_d = (cnt_d == '0) && (s1 == db_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      db_q <= '0;
      cnt_q <= '0;
      settled_q <= 1'b1;
    end else begin
      s1 <= bus.sw;
      s2 <= s1;
      db_q <= db_d;
      cnt_q <= cnt_d;
      settled_q <= settled_d;
    end
  end
  assign bus.sw_db = db_q;
  assign bus.settled = settled_q;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, fall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`else
  assign bus.rise = '0;
  assign bus.fall = '0;
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed steps with a cycle-tagged expectation queue, CNT_MAX = 4.
module tb_sw_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  typedef struct {
    int         due;
    string      tag;
    logic [7:0] db, r, f;
    logic       st;
  } exp_t;
  exp_t sb[$];
  sw_debounce_if #(.WIDTH(8)) bus ();
  sw_debounce #(.WIDTH(8), .CNT_MAX(4), .CNT_W(20)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] ep(logic [7:0] v);
`ifdef SW_DEBOUNCE_EDGE_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction
  task automatic chk(string tag, logic [7:0] got, logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  // k = number of edges after the next one (edge n + k)
  task automatic expect_at(int k, string tag, logic [7:0] db, logic [7:0] r, logic [7:0] f, logic st);
    exp_t e;
    e.due = cyc + 1 + k; e.tag = tag; e.db = db; e.r = ep(r); e.f = ep(f); e.st = st;
    sb.push_back(e);
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk({e.tag, ".sw_db"}, bus.sw_db, e.db);
      chk({e.tag, ".rise"}, bus.rise, e.r);
      chk({e.tag, ".fall"}, bus.fall, e.f);
      chk({e.tag, ".settled"}, {7'd0, bus.settled}, {7'd0, e.st});
    end
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    bus.sw = 8'hFF;
    rst = 1'b1;
    expect_at(2, "reset", 8'h00, 8'h00, 8'h00, 1'b1);
    ticks(3);
    rst = 1'b0;
    expect_at(0, "rel_n0", 8'h00, 8'h00, 8'h00, 1'b1);
    expect_at(1, "rel_n1", 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(4, "rel_n4", 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(5, "rel_n5", 8'hFF, 8'hFF, 8'h00, 1'b1);
    expect_at(6, "rel_n6", 8'hFF, 8'h00, 8'h00, 1'b1);
    ticks(8);
    bus.sw = 8'h00;
    expect_at(5, "clr_n5", 8'h00, 8'h00, 8'hFF, 1'b1);
    expect_at(6, "clr_n6", 8'h00, 8'h00, 8'h00, 1'b1);
    ticks(8);
    bus.sw = 8'h05;
    expect_at(0, "clean_n0", 8'h00, 8'h00, 8'h00, 1'b1);
    expect_at(1, "clean_n1", 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(4, "clean_n4", 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(5, "clean_n5", 8'h05, 8'h05, 8'h00, 1'b1);
    expect_at(6, "clean_n6", 8'h05, 8'h00, 8'h00, 1'b1);
    ticks(8);
    bus.sw = 8'h0D; tick();
    bus.sw = 8'h05; tick();
    bus.sw = 8'h0D; tick();
    bus.sw = 8'h05; tick();
    bus.sw = 8'h0D;
    expect_at(3, "bounce_n3", 8'h05, 8'h00, 8'h00, 1'b0);
    expect_at(4, "bounce_n4", 8'h05, 8'h00, 8'h00, 1'b0);
    expect_at(5, "bounce_n5", 8'h0D, 8'h08, 8'h00, 1'b1);
    expect_at(6, "bounce_n6", 8'h0D, 8'h00, 8'h00, 1'b1);
    ticks(8);
    bus.sw = 8'h8D;
    expect_at(4, "glitch_n4", 8'h0D, 8'h00, 8'h00, 1'b0);
    expect_at(5, "glitch_n5", 8'h0D, 8'h00, 8'h00, 1'b1);
    expect_at(6, "glitch_n6", 8'h0D, 8'h00, 8'h00, 1'b1);
    expect_at(8, "glitch_n8", 8'h0D, 8'h00, 8'h00, 1'b1);
    ticks(3);
    bus.sw = 8'h0D;
    ticks(7);
    bus.sw = 8'hF0;
    expect_at(5, "to_f0", 8'hF0, 8'hF0, 8'h0D, 1'b1);
    ticks(8);
    bus.sw = 8'h0F;
    expect_at(4, "simul_n4", 8'hF0, 8'h00, 8'h00, 1'b0);
    expect_at(5, "simul_n5", 8'h0F, 8'h0F, 8'hF0, 1'b1);
    expect_at(6, "simul_n6", 8'h0F, 8'h00, 8'h00, 1'b1);
    ticks(8);
    bus.sw = 8'hF0;
    expect_at(2, "midrst_n2", 8'h0F, 8'h00, 8'h00, 1'b0);
    expect_at(3, "midrst_n3", 8'h00, 8'h00, 8'h00, 1'b1);
    ticks(3);
    rst = 1'b1;
    bus.sw = 8'h00;
    tick();
    expect_at(0, "midrst_r", 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    rst = 1'b0;
    expect_at(2, "midrst_q2", 8'h00, 8'h00, 8'h00, 1'b1);
    expect_at(6, "midrst_q6", 8'h00, 8'h00, 8'h00, 1'b1);
    ticks(8);
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
